// File: rtl/uart_prog_loader.sv
// uart_prog_loader
//   Sequences a program download through uart_rx_prog. Supplies the receiver's
//   baud divisor and packs received bytes into little-endian 32-bit words. Each
//   word is written to instruction memory over a valid/grant handshake at
//   incrementing word addresses. Loading stops on an end-of-program marker word
//   or when the address space fills. Errors are reported as sticky flags.
//
// Parameters
//   ADDR_W    word-address width; memory holds 2**ADDR_W words
//   END_WORD  end-of-program marker word; never written to memory
//
// Ports
//   i_Clock         clock, rising edge
//   rst_ni          asynchronous active-low reset
//   i_start         1-cycle pulse: begin a load (honoured only in IDLE/DONE)
//   i_clks_per_bit  baud divisor, captured on an accepted start
//   o_clks_per_bit  captured divisor for uart_rx_prog
//   i_rx_dv         received-byte strobe
//   i_rx_byte       received byte
//   o_we            memory write request (valid)
//   i_gnt           memory grant (ready)
//   o_addr          word address of the current write
//   o_wdata         write data
//   o_busy          high while loading or draining the last write
//   o_done          sticky: load finished
//   o_err           sticky: [0] word overrun, [1] address space full
module uart_prog_loader #(
    parameter int          ADDR_W   = 14,
    parameter logic [31:0] END_WORD = 32'h00000FFF
) (
    input  logic              i_Clock,
    input  logic              rst_ni,
    input  logic              i_start,
    input  logic [15:0]       i_clks_per_bit,
    output logic [15:0]       o_clks_per_bit,
    input  logic              i_rx_dv,
    input  logic [7:0]        i_rx_byte,
    output logic              o_we,
    input  logic              i_gnt,
    output logic [ADDR_W-1:0] o_addr,
    output logic [31:0]       o_wdata,
    output logic              o_busy,
    output logic              o_done,
    output logic [1:0]        o_err
);

    typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

    state_t            state_q, state_d;
    logic [1:0]        cnt_q;
    logic [23:0]       asm_q;
    logic              pending_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic              done_q;
    logic [1:0]        err_q;
    logic [15:0]       clks_q;

    logic        start_ok, byte_en, word_done, is_marker;
    logic        xfer, full_hit, pending_after, take_word, load_word, overrun;
    logic [31:0] word;

    always_comb begin
        start_ok      = i_start && (state_q == IDLE || state_q == DONE);
        byte_en       = (state_q == LOAD) && i_rx_dv;
        word_done     = byte_en && (cnt_q == 2'd3);
        word          = {i_rx_byte, asm_q};
        is_marker     = (word == END_WORD);
        xfer          = pending_q && i_gnt;
        full_hit      = xfer && (addr_q == ADDR_MAX);
        // Pending state as seen by a word completing this cycle: a same-cycle
        // grant frees the slot for the new word.
        pending_after = pending_q && !i_gnt;
        // A word completing alongside the final transfer is discarded.
        take_word     = word_done && !full_hit && !is_marker;
        overrun       = take_word && pending_after;
        load_word     = take_word && !pending_after;
    end

    always_ff @(posedge i_Clock or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: if (start_ok) state_d = LOAD;
            LOAD: begin
                if (full_hit)                    state_d = DONE;
                else if (word_done && is_marker) state_d = pending_after ? DRAIN : DONE;
            end
            DRAIN: if (xfer) state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_Clock or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q     <= '0;
            asm_q     <= '0;
            pending_q <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            done_q    <= 1'b0;
            err_q     <= '0;
            clks_q    <= '0;
        end else if (start_ok) begin
            cnt_q     <= '0;
            asm_q     <= '0;
            pending_q <= 1'b0;
            addr_q    <= '0;
            done_q    <= 1'b0;
            err_q     <= '0;
            clks_q    <= i_clks_per_bit;
        end else begin
            if (byte_en) begin
                cnt_q <= cnt_q + 2'd1;
                case (cnt_q)
                    2'd0:    asm_q[7:0]   <= i_rx_byte;
                    2'd1:    asm_q[15:8]  <= i_rx_byte;
                    2'd2:    asm_q[23:16] <= i_rx_byte;
                    default: asm_q        <= '0;
                endcase
            end
            if (xfer) begin
                if (addr_q == ADDR_MAX) err_q[1] <= 1'b1;
                else                    addr_q   <= addr_q + 1'b1;
            end
            if (load_word) begin
                wdata_q   <= word;
                pending_q <= 1'b1;
            end else if (xfer) begin
                pending_q <= 1'b0;
            end
            if (overrun) err_q[0] <= 1'b1;
            done_q <= (state_d == DONE);
        end
    end

    assign o_clks_per_bit = clks_q;
    assign o_we           = pending_q;
    assign o_addr         = addr_q;
    assign o_wdata        = wdata_q;
    assign o_busy         = (state_q == LOAD) || (state_q == DRAIN);
    assign o_done         = done_q;
    assign o_err          = err_q;

endmodule
